// File: rtl/msi_cache_ctrl_pkg.sv
// Shared types for the MSI cache controller.
//   blk_state_t : per-line coherence state exchanged with the cache array
//   state_t     : controller FSM state
//   pick_word / merge_word : 16-bit word select / replace within a 64-bit line
package common;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    SHARED   = 2'd1,
    MODIFIED = 2'd2
  } blk_state_t;

  typedef enum logic [2:0] {
    IDLE, COMPARE, BUS_REQ, WB, FILL, UPGR
  } state_t;

  localparam int LINE_W = 11;
  localparam int TAG_W  = 5;
  localparam int IDX_W  = 6;
  localparam int WORD_W = 16;
  localparam int DATA_W = 64;

  function automatic logic [WORD_W-1:0] pick_word(input logic [DATA_W-1:0] line,
                                                  input logic [1:0]        sel);
    return line[{sel, 4'b0000} +: WORD_W];
  endfunction

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] line,
                                                   input logic [1:0]        sel,
                                                   input logic [WORD_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = line;
    r[{sel, 4'b0000} +: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/msi_cache_ctrl.sv
// MSI cache controller: one outstanding CPU request, direct-mapped cache
// (64 sets, 5-bit tag), snooping bus with invalidate broadcast.
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   cpu_rd/cpu_wr/cpu_addr/...  : CPU request (level, held until cpu_rdy)
//   cpu_rdata/cpu_rdy           : read data and one-cycle completion pulse
//   c_*                         : cache array; reads registered (result valid
//                                 the cycle after c_re), writes on c_we
//   mem_*                       : line-wide memory, phase done on mem_rdy
//   bus_req/bus_gnt             : bus ownership for miss/upgrade handling
//   bus_inval/bus_inval_addr    : invalidate pulse to peer caches
//   hit_cnt/miss_cnt            : saturating counters, only with PERF_CNT_EN
//
// Optional feature macro: PERF_CNT_EN
module msi_cache_ctrl
  import common::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [12:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_rdy,
  output logic [10:0]       c_addr,
  output logic [63:0]       c_wr_data,
  output blk_state_t        c_wstate,
  output logic              c_we,
  output logic              c_re,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  blk_state_t        c_rstate,
  input  logic [63:0]       c_rd_data,
  input  logic [4:0]        c_tag_out,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [10:0]       mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_rdy,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_inval,
  output logic [10:0]       bus_inval_addr
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
`endif
);

  state_t             state_q, state_d;
  logic               op_wr_q, op_wr_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [1:0]         word_q, word_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               upg_q, upg_d;
  // Line contents seen in COMPARE: victim data on a miss, base for the
  // merged write on an upgrade.
  logic [DATA_W-1:0]  ldata_q, ldata_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;
  logic               vdirty_q, vdirty_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_wr_q  <= 1'b0;
      line_q   <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      upg_q    <= 1'b0;
      ldata_q  <= '0;
      vtag_q   <= '0;
      vdirty_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_wr_q  <= op_wr_d;
      line_q   <= line_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      upg_q    <= upg_d;
      ldata_q  <= ldata_d;
      vtag_q   <= vtag_d;
      vdirty_q <= vdirty_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_wr_d        = op_wr_q;
    line_d         = line_q;
    word_d         = word_q;
    wdata_d        = wdata_q;
    upg_d          = upg_q;
    ldata_d        = ldata_q;
    vtag_d         = vtag_q;
    vdirty_d       = vdirty_q;
    cpu_rdata      = '0;
    cpu_rdy        = 1'b0;
    c_addr         = '0;
    c_wr_data      = '0;
    c_wstate       = INVALID;
    c_we           = 1'b0;
    c_re           = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    bus_req        = 1'b0;
    bus_inval      = 1'b0;
    bus_inval_addr = '0;

    // Outputs are forced quiet while reset is held, even mid-transaction.
    if (!rst) begin
      c_addr         = line_q;
      bus_inval_addr = line_q;
      unique case (state_q)
        IDLE: begin
          // Cache lookup is issued straight from the CPU address so the
          // tag/data come back in COMPARE.
          c_addr = cpu_addr[12:2];
          if (cpu_rd || cpu_wr) begin
            op_wr_d = cpu_wr;
            line_d  = cpu_addr[12:2];
            word_d  = cpu_addr[1:0];
            wdata_d = cpu_wdata;
            upg_d   = 1'b0;
            c_re    = 1'b1;
            state_d = COMPARE;
          end
        end

        COMPARE: begin
          ldata_d  = c_rd_data;
          vtag_d   = c_tag_out;
          vdirty_d = c_dirty;
          if (c_hit) begin
            if (!op_wr_q) begin
              cpu_rdata = pick_word(c_rd_data, word_q);
              cpu_rdy   = 1'b1;
              state_d   = IDLE;
            end else if (c_rstate == MODIFIED) begin
              c_we      = 1'b1;
              c_wr_data = merge_word(c_rd_data, word_q, wdata_q);
              c_wstate  = MODIFIED;
              cpu_rdy   = 1'b1;
              state_d   = IDLE;
            end else begin
              // Write to a SHARED line: needs the bus to invalidate peers.
              upg_d   = 1'b1;
              state_d = BUS_REQ;
            end
          end else begin
            upg_d   = 1'b0;
            state_d = BUS_REQ;
          end
        end

        BUS_REQ: begin
          bus_req = 1'b1;
          if (bus_gnt) begin
            if (upg_q)         state_d = UPGR;
            else if (vdirty_q) state_d = WB;
            else               state_d = FILL;
          end
        end

        WB: begin
          bus_req   = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = {vtag_q, line_q[IDX_W-1:0]};
          mem_wdata = ldata_q;
          if (mem_rdy) state_d = FILL;
        end

        FILL: begin
          bus_req  = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = line_q;
          if (mem_rdy) begin
            c_we      = 1'b1;
            c_wr_data = op_wr_q ? merge_word(mem_rdata, word_q, wdata_q) : mem_rdata;
            c_wstate  = op_wr_q ? MODIFIED : SHARED;
            bus_inval = op_wr_q;
            cpu_rdata = op_wr_q ? '0 : pick_word(mem_rdata, word_q);
            cpu_rdy   = 1'b1;
            state_d   = IDLE;
          end
        end

        UPGR: begin
          bus_req   = 1'b1;
          bus_inval = 1'b1;
          c_we      = 1'b1;
          c_wr_data = merge_word(ldata_q, word_q, wdata_q);
          c_wstate  = MODIFIED;
          cpu_rdy   = 1'b1;
          state_d   = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Every lookup resolves in COMPARE exactly once; an upgrade is a hit.
  logic             hit_ev, miss_ev;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  assign hit_ev  = !rst && (state_q == COMPARE) && c_hit;
  assign miss_ev = !rst && (state_q == COMPARE) && !c_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ev && (hit_cnt_q != {CNT_W{1'b1}}))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_ev && (miss_cnt_q != {CNT_W{1'b1}})) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_msi_cache_ctrl.sv
module tb_msi_cache_ctrl;
  import common::*;

`ifdef PERF_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_rdy;
  logic [10:0] c_addr;
  logic [63:0] c_wr_data;
  blk_state_t  c_wstate;
  logic        c_we, c_re;
  logic        c_hit, c_dirty;
  blk_state_t  c_rstate;
  logic [63:0] c_rd_data;
  logic [4:0]  c_tag_out;
  logic        mem_rd, mem_wr, mem_rdy;
  logic [10:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        bus_req, bus_gnt, bus_inval;
  logic [10:0] bus_inval_addr;
`ifdef PERF_CNT_EN
  logic [CW-1:0] hit_cnt, miss_cnt;
`endif

  msi_cache_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .c_addr(c_addr), .c_wr_data(c_wr_data), .c_wstate(c_wstate), .c_we(c_we),
    .c_re(c_re), .c_hit(c_hit), .c_dirty(c_dirty), .c_rstate(c_rstate),
    .c_rd_data(c_rd_data), .c_tag_out(c_tag_out),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_inval(bus_inval),
    .bus_inval_addr(bus_inval_addr)
`ifdef PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // ---------------- cache array model (registered read) ----------------
  blk_state_t  st_m  [64] = '{default: INVALID};
  logic [4:0]  tag_m [64] = '{default: 5'd0};
  logic [63:0] dat_m [64] = '{default: 64'd0};
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  blk_state_t  pl_st = INVALID;
  logic [4:0]  pl_tag = '0;
  logic [63:0] pl_dat = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      st_m[pl_idx]  <= pl_st;
      tag_m[pl_idx] <= pl_tag;
      dat_m[pl_idx] <= pl_dat;
    end else if (c_we) begin
      st_m[c_addr[5:0]]  <= c_wstate;
      tag_m[c_addr[5:0]] <= c_addr[10:6];
      dat_m[c_addr[5:0]] <= c_wr_data;
    end
    if (c_re) begin
      c_hit     <= (st_m[c_addr[5:0]] != INVALID) && (tag_m[c_addr[5:0]] == c_addr[10:6]);
      c_dirty   <= (st_m[c_addr[5:0]] == MODIFIED);
      c_rstate  <= st_m[c_addr[5:0]];
      c_rd_data <= dat_m[c_addr[5:0]];
      c_tag_out <= tag_m[c_addr[5:0]];
    end
  end

  // ---------------- memory and bus models ----------------
  int mem_lat = 0, gnt_lat = 0, mcnt = 0, gcnt = 0;

  function automatic logic [63:0] memfn(input logic [10:0] a);
    return {3'd3, 2'b00, a, 3'd2, 2'b00, a, 3'd1, 2'b00, a, 3'd0, 2'b00, a};
  endfunction

  assign mem_rdy   = (mem_rd || mem_wr) && (mcnt >= mem_lat);
  assign mem_rdata = memfn(mem_addr);
  assign bus_gnt   = bus_req && (gcnt >= gnt_lat);

  always @(posedge clk) begin
    mcnt <= ((mem_rd || mem_wr) && !mem_rdy) ? mcnt + 1 : 0;
    gcnt <= (bus_req && !bus_gnt) ? gcnt + 1 : 0;
  end

  // ---------------- activity counters ----------------
  int          cyc = 0, n_breq = 0, n_mwr = 0, n_mrd = 0, n_both = 0, n_we = 0, n_inv = 0;
  int          wb_done_cyc = 0, rd_done_cyc = 0;
  logic [10:0] last_wb_addr = '0, last_rd_addr = '0;
  logic [63:0] last_wb_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus_req)            n_breq <= n_breq + 1;
      if (mem_wr)             n_mwr  <= n_mwr + 1;
      if (mem_rd)             n_mrd  <= n_mrd + 1;
      if (mem_rd && mem_wr)   n_both <= n_both + 1;
      if (c_we)               n_we   <= n_we + 1;
      if (bus_inval)          n_inv  <= n_inv + 1;
      if (mem_wr && mem_rdy) begin
        last_wb_addr <= mem_addr;
        last_wb_data <= mem_wdata;
        wb_done_cyc  <= cyc;
      end
      if (mem_rd && mem_rdy) begin
        last_rd_addr <= mem_addr;
        rd_done_cyc  <= cyc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        chk;
    logic [15:0] rd;
    logic [10:0] line;
  } exp_t;
  exp_t q[$];

  int checks = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus_inval) begin
        if (q.size() == 0) check("inval_unexpected", {63'd0, bus_inval}, 64'd0);
        else               check("inval_addr", {53'd0, bus_inval_addr}, {53'd0, q[0].line});
      end
      if (!rst && cpu_rdy) begin
        if (q.size() == 0) begin
          check("rdy_unexpected", {63'd0, cpu_rdy}, 64'd0);
        end else begin
          e = q.pop_front();
          if (e.chk) check("rdata", {48'd0, cpu_rdata}, {48'd0, e.rd});
        end
      end
    end
  endtask

  task automatic preload(input logic [5:0] idx, input blk_state_t s,
                         input logic [4:0] tg, input logic [63:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_st = s; pl_tag = tg; pl_dat = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, hold it until cpu_rdy, report latency in cycles.
  task automatic do_req(input string name, input logic wr, input logic [12:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd,
                        input int exp_we, output int lat);
    exp_t e;
    int   we0;
    logic got;
    e.chk = !wr; e.rd = exp_rd; e.line = a[12:2];
    q.push_back(e);
    @(posedge clk); #1;
    we0 = n_we;
    cpu_rd = !wr; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_rdy) got = 1'b1;
    end
    check({name, "_rdy_seen"}, {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    check({name, "_we_count"}, 64'(n_we - we0), 64'(exp_we));
  endtask

  int lat, b0, i0, w0, r0, nr;
  logic seen;

  initial begin
    fork
      monitor();
    join_none

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rdy", {63'd0, cpu_rdy}, 64'd0);
    check("rst_bus_req", {63'd0, bus_req}, 64'd0);
    check("rst_mem", {62'd0, mem_rd, mem_wr}, 64'd0);
    check("rst_c_we", {62'd0, c_we, c_re}, 64'd0);
    check("rst_wstate", {62'd0, c_wstate}, {62'd0, INVALID});
    @(posedge clk); #1 rst = 1'b0;

    // ---- read hit, SHARED line 0x045 ----
    preload(6'd5, SHARED, 5'd1, 64'h4444_3333_2222_1111);
    b0 = n_breq;
    do_req("rd_hit", 1'b0, 13'h116, 16'h0, 16'h3333, 0, lat);
    check("rd_hit_lat", 64'(lat), 64'd2);
    check("rd_hit_busreq", 64'(n_breq - b0), 64'd0);

    // ---- write hit on SHARED: upgrade ----
    gnt_lat = 3; i0 = n_inv; w0 = n_mwr; r0 = n_mrd;
    do_req("upg", 1'b1, 13'h116, 16'hBEEF, 16'h0, 1, lat);
    check("upg_inval_cnt", 64'(n_inv - i0), 64'd1);
    check("upg_state", {62'd0, st_m[5]}, {62'd0, MODIFIED});
    check("upg_data", dat_m[5], 64'h4444_BEEF_2222_1111);
    check("upg_no_mem", 64'((n_mwr - w0) + (n_mrd - r0)), 64'd0);

    // ---- write hit on MODIFIED ----
    gnt_lat = 0; b0 = n_breq;
    do_req("wr_hit_m", 1'b1, 13'h114, 16'h1234, 16'h0, 1, lat);
    check("wr_hit_m_lat", 64'(lat), 64'd2);
    check("wr_hit_m_data", dat_m[5], 64'h4444_BEEF_2222_1234);
    check("wr_hit_m_busreq", 64'(n_breq - b0), 64'd0);

    // ---- dirty miss: victim tag 3 written back, tag 7 filled ----
    preload(6'd5, MODIFIED, 5'd3, 64'hDDDD_CCCC_BBBB_AAAA);
    mem_lat = 2;
    do_req("dirty_miss", 1'b0, 13'h715, 16'h0, 16'h21C5, 1, lat);
    check("wb_addr", {53'd0, last_wb_addr}, {53'd0, 11'h0C5});
    check("wb_data", last_wb_data, 64'hDDDD_CCCC_BBBB_AAAA);
    check("fill_addr", {53'd0, last_rd_addr}, {53'd0, 11'h1C5});
    check("wb_before_fill", {63'd0, wb_done_cyc < rd_done_cyc}, 64'd1);
    check("dm_state", {62'd0, st_m[5]}, {62'd0, SHARED});
    check("dm_tag", {59'd0, tag_m[5]}, 64'd7);
    check("dm_data", dat_m[5], 64'h61C5_41C5_21C5_01C5);

    // ---- clean read miss, zero-latency memory and grant ----
    mem_lat = 0; w0 = n_mwr;
    do_req("clean_miss0", 1'b0, 13'h024, 16'h0, 16'h0009, 1, lat);
    check("clean_miss0_lat", 64'(lat), 64'd4);
    check("clean_miss0_state", {62'd0, st_m[9]}, {62'd0, SHARED});
    check("clean_miss0_data", dat_m[9], 64'h6009_4009_2009_0009);

    // ---- clean write miss, memory latency 10 ----
    preload(6'd10, SHARED, 5'd2, 64'h1111_2222_3333_4444);
    mem_lat = 10; gnt_lat = 2; i0 = n_inv;
    do_req("clean_miss10", 1'b1, 13'h42B, 16'hCAFE, 16'h0, 1, lat);
    check("clean_miss10_state", {62'd0, st_m[10]}, {62'd0, MODIFIED});
    check("clean_miss10_tag", {59'd0, tag_m[10]}, 64'd4);
    check("clean_miss10_data", dat_m[10], 64'hCAFE_410A_210A_010A);
    check("clean_miss10_inval", 64'(n_inv - i0), 64'd1);
    check("clean_no_mem_wr", 64'(n_mwr - w0), 64'd0);
    check("never_rd_and_wr", 64'(n_both), 64'd0);

    // ---- reset during write-back ----
    preload(6'd12, MODIFIED, 5'd1, 64'h5555_6666_7777_8888);
    mem_lat = 20; gnt_lat = 0; w0 = n_we;
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 13'h230;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_wr) seen = 1'b1;
    end
    check("rstwb_reached_wb", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; cpu_rd = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstwb_mem_wr", {63'd0, mem_wr}, 64'd0);
    check("rstwb_bus_req", {63'd0, bus_req}, 64'd0);
    check("rstwb_state", {62'd0, st_m[12]}, {62'd0, MODIFIED});
    check("rstwb_data", dat_m[12], 64'h5555_6666_7777_8888);
    check("rstwb_no_we", 64'(n_we - w0), 64'd0);
    mem_lat = 0;

    // ---- five read hits (counter saturation with PERF_CNT_EN) ----
    for (int k = 0; k < 5; k++) begin
      do_req("hit_loop", 1'b0, 13'h715, 16'h0, 16'h21C5, 0, lat);
      check("hit_loop_lat", 64'(lat), 64'd2);
    end
`ifdef PERF_CNT_EN
    @(negedge clk);
    check("hit_cnt_sat", {62'd0, hit_cnt}, 64'd3);
    check("miss_cnt", {62'd0, miss_cnt}, 64'd0);
`endif

    // ---- request held across cpu_rdy is accepted again ----
    q.push_back('{chk: 1'b1, rd: 16'h0009, line: 11'h009});
    q.push_back('{chk: 1'b1, rd: 16'h0009, line: 11'h009});
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 13'h024;
    nr = 0; lat = 0;
    for (int i = 0; i < 20 && nr < 2; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_rdy) nr++;
    end
    @(posedge clk); #1 cpu_rd = 1'b0;
    check("held_two_rdys", 64'(nr), 64'd2);
    check("held_total_lat", 64'(lat), 64'd4);
    repeat (3) @(posedge clk);
    check("sb_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
